// File: rtl/mem_copy.sv
// mem_copy: single-channel word copier. Reads one word from the source
// range, writes it to the destination range, and repeats in ascending
// address order. Requests whose source or destination range runs past the
// end of memory are rejected with a one-cycle err pulse.
module mem_copy #(
    parameter int MEM_WORDS = 500,
    parameter int AW        = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    input  logic [15:0]   mem_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        FIN   = 3'd3,
        FAIL  = 3'd4
    } state_t;

    // One extra bit so that address + length can never wrap around.
    localparam logic [AW:0] MEM_LIMIT = (AW+1)'(MEM_WORDS);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] src_l;
    logic [AW-1:0] dst_l;
    logic [AW-1:0] len_l;
    logic [15:0]   hold;
    logic [AW:0]   src_end;
    logic [AW:0]   dst_end;
    logic          range_bad;
    logic [AW-1:0] count_inc;
    logic          accept;

    assign src_end   = {1'b0, src} + {1'b0, len};
    assign dst_end   = {1'b0, dst} + {1'b0, len};
    assign range_bad = (src_end > MEM_LIMIT) || (dst_end > MEM_LIMIT);
    assign count_inc = count + 1'b1;
    assign accept    = (state == IDLE) && start;
    assign mem_wdata = hold;

    // State register; reset returns to IDLE regardless of the clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Words-written counter and read-data hold register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            hold  <= '0;
        end else begin
            if (accept) begin
                count <= '0;
            end else if (state == WRITE) begin
                count <= count_inc;
            end
            if (state == READ) begin
                hold <= mem_rdata;
            end
        end
    end

    // Request parameters are captured once at acceptance and then frozen.
    always_ff @(posedge clk) begin
        if (accept) begin
            src_l <= src;
            dst_l <= dst;
            len_l <= len;
        end
    end

    // Next-state selection and per-state memory/status outputs.
    always_comb begin
        state_nxt = state;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        done      = 1'b0;
        err       = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    if (range_bad) begin
                        state_nxt = FAIL;
                    end else if (len == '0) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                mem_re    = 1'b1;
                mem_addr  = src_l + count;
                state_nxt = WRITE;
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = dst_l + count;
                state_nxt = (count_inc == len_l) ? FIN : READ;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            FAIL: begin
                err       = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy.sv
// Directed bench for mem_copy with an asynchronous-read memory model and
// a negedge bus monitor that logs every read and write.
module tb_mem_copy;

    localparam int MW = 500;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW-1:0] len;
    logic [15:0]   mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          mem_re;
    logic          mem_we;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] count;

    logic [15:0] mem [0:MW-1];

    int n_cmp = 0;
    int n_bad = 0;

    int log_kind [0:255];
    int log_addr [0:255];
    int log_data [0:255];
    int nlog     = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int busy_cnt = 0;
    int both_cnt = 0;

    mem_copy #(.MEM_WORDS(MW), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    assign mem_rdata = (int'(mem_addr) < MW) ? mem[int'(mem_addr)] : 16'h0000;

    always @(posedge clk) begin
        if (mem_we && int'(mem_addr) < MW) mem[int'(mem_addr)] = mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_re && mem_we) both_cnt++;
        if (mem_re && nlog < 256) begin
            log_kind[nlog] = 0; log_addr[nlog] = int'(mem_addr); log_data[nlog] = int'(mem_rdata);
            nlog++;
        end
        if (mem_we && nlog < 256) begin
            log_kind[nlog] = 1; log_addr[nlog] = int'(mem_addr); log_data[nlog] = int'(mem_wdata);
            nlog++;
        end
        if (done) done_cnt++;
        if (err)  err_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int s, input int d, input int l);
        @(negedge clk);
        start = 1'b1; src = AW'(s); dst = AW'(d); len = AW'(l);
        @(negedge clk);
        start = 1'b0; src = '0; dst = '0; len = '0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_log, b_done, b_err, b_busy;
        for (int i = 0; i < MW; i++) mem[i] = 16'h0000;
        reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;

        // reset state
        #3;
        chk("rst_busy", int'(busy), 0);
        chk("rst_re", int'(mem_re), 0);
        chk("rst_we", int'(mem_we), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_wdata", int'(mem_wdata), 0);
        @(negedge clk);
        reset = 1'b0;

        // basic copy 10..13 -> 100..103
        for (int i = 0; i < 4; i++) mem[10+i] = 16'(16'hA0 + i);
        b_log = nlog; b_done = done_cnt; b_busy = busy_cnt;
        do_start(10, 100, 4);
        wait_idle(30);
        chk("basic_busy_cycles", busy_cnt - b_busy, 9);
        chk("basic_nlog", nlog - b_log, 8);
        for (int i = 0; i < 4; i++) begin
            chk("basic_rd_kind", log_kind[b_log+2*i], 0);
            chk("basic_rd_addr", log_addr[b_log+2*i], 10 + i);
            chk("basic_wr_kind", log_kind[b_log+2*i+1], 1);
            chk("basic_wr_addr", log_addr[b_log+2*i+1], 100 + i);
            chk("basic_wr_data", log_data[b_log+2*i+1], 16'hA0 + i);
            chk("basic_mem", int'(mem[100+i]), 16'hA0 + i);
        end
        chk("basic_done", done_cnt - b_done, 1);
        chk("basic_count", int'(count), 4);
        @(negedge clk);
        chk("count_holds_idle", int'(count), 4);

        // zero length
        b_log = nlog; b_done = done_cnt;
        do_start(5, 6, 0);
        chk("zero_done_fin", int'(done), 1);
        chk("zero_busy_fin", int'(busy), 1);
        chk("zero_re_fin", int'(mem_re), 0);
        chk("zero_we_fin", int'(mem_we), 0);
        chk("zero_count", int'(count), 0);
        @(negedge clk);
        chk("zero_done_after", int'(done), 0);
        chk("zero_busy_after", int'(busy), 0);
        chk("zero_nlog", nlog - b_log, 0);
        chk("zero_done_cnt", done_cnt - b_done, 1);

        // range check: 498+3 > 500 rejected
        b_log = nlog; b_done = done_cnt; b_err = err_cnt;
        do_start(498, 0, 3);
        chk("range_err_pulse", int'(err), 1);
        chk("range_busy_fail", int'(busy), 1);
        wait_idle(10);
        @(negedge clk);
        chk("range_err_cnt", err_cnt - b_err, 1);
        chk("range_no_done", done_cnt - b_done, 0);
        chk("range_nlog", nlog - b_log, 0);
        chk("range_count", int'(count), 0);

        // range check: 497+3 == 500 accepted
        mem[497] = 16'h51; mem[498] = 16'h52; mem[499] = 16'h53;
        b_log = nlog; b_done = done_cnt; b_err = err_cnt;
        do_start(497, 0, 3);
        wait_idle(20);
        chk("edge_nlog", nlog - b_log, 6);
        chk("edge_last_rd_kind", log_kind[nlog-2], 0);
        chk("edge_last_rd_addr", log_addr[nlog-2], 499);
        chk("edge_mem2", int'(mem[2]), 16'h53);
        chk("edge_done", done_cnt - b_done, 1);
        chk("edge_no_err", err_cnt - b_err, 0);

        // overlapping ranges propagate the first word upward
        mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3; mem[3] = 16'd0;
        do_start(0, 1, 3);
        wait_idle(20);
        chk("ovl_mem0", int'(mem[0]), 1);
        chk("ovl_mem1", int'(mem[1]), 1);
        chk("ovl_mem2", int'(mem[2]), 1);
        chk("ovl_mem3", int'(mem[3]), 1);

        // reset during the second WRITE
        for (int i = 0; i < 4; i++) begin
            mem[20+i]  = 16'(16'h71 + i);
            mem[200+i] = 16'h0000;
        end
        b_done = done_cnt; b_err = err_cnt;
        do_start(20, 200, 4);
        repeat (3) @(negedge clk);
        #1;
        chk("mid_we_before", int'(mem_we), 1);
        chk("mid_addr_before", int'(mem_addr), 201);
        reset = 1'b1;
        #1;
        chk("mid_re", int'(mem_re), 0);
        chk("mid_we", int'(mem_we), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_count", int'(count), 0);
        chk("mid_addr", int'(mem_addr), 0);
        chk("mid_wdata", int'(mem_wdata), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_mem200", int'(mem[200]), 16'h71);
        chk("mid_mem201", int'(mem[201]), 0);
        chk("mid_mem202", int'(mem[202]), 0);
        chk("mid_no_done", done_cnt - b_done, 0);
        chk("mid_no_err", err_cnt - b_err, 0);
        chk("mid_idle", int'(busy), 0);

        // start while busy and start during FIN are both ignored
        mem[30] = 16'h91; mem[31] = 16'h92;
        for (int i = 0; i < 3; i++) begin
            mem[40+i]  = 16'(16'h11 + i);
            mem[400+i] = 16'h0000;
        end
        mem[300] = 16'h0000; mem[301] = 16'h0000;
        b_log = nlog; b_done = done_cnt;
        do_start(30, 300, 2);
        @(negedge clk);
        start = 1'b1; src = 16'd40; dst = 16'd400; len = 16'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_fin_done", int'(done), 1);
        start = 1'b1; src = 16'd40; dst = 16'd400; len = 16'd3;
        @(negedge clk);
        start = 1'b0; src = '0; dst = '0; len = '0;
        chk("busy_after_fin", int'(busy), 0);
        @(negedge clk);
        chk("busy_stays_idle", int'(busy), 0);
        chk("busy_nlog", nlog - b_log, 4);
        chk("busy_mem300", int'(mem[300]), 16'h91);
        chk("busy_mem301", int'(mem[301]), 16'h92);
        chk("busy_mem400", int'(mem[400]), 0);
        chk("busy_count", int'(count), 2);
        chk("busy_done_cnt", done_cnt - b_done, 1);

        chk("re_we_exclusive", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
